// File: rtl/data_bus_responder.sv
// data_bus_responder: core data-port responder, decodes on-chip RAM and a memory-mapped UART transmitter.
// Latency: loads return on dout one cycle after the access; stores and TX pushes take effect at the edge.
// Backpressure: none on the bus; a TX push into a full FIFO is dropped and flagged sticky in STATUS.ovf.
module data_bus_responder #(
  parameter int ADDR_W       = 12,
  parameter int FIFO_LOG     = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] di,
  output logic [31:0] dout,
  output logic        txd
);

  localparam int DEPTH  = 1 << FIFO_LOG;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_LOG:0] CNT_FULL  = (FIFO_LOG + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // Access decode: top nibble F selects MMIO, word address picks the register
  logic              ld, st, is_mmio, sel_tx, sel_st;
  logic [ADDR_W-1:0] ram_idx;
  logic              unused_addr;

  assign ld          = en & ~we;
  assign st          = en & we;
  assign is_mmio     = (addr[31:28] == 4'hF);
  assign sel_tx      = (addr[31:2] == 30'h3C00_0000);
  assign sel_st      = (addr[31:2] == 30'h3C00_0001);
  assign ram_idx     = addr[ADDR_W+1:2];
  assign unused_addr = ^addr[1:0];

  // Data RAM: single write port, read captured into dout on loads
  logic [31:0] ram_q [2**ADDR_W];

  // RAM write port; contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (st && !is_mmio) ram_q[ram_idx] <= di;
  end

  // TX byte FIFO
  logic [7:0]          fifo_q [DEPTH];
  logic [FIFO_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG:0]   count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                push_req, push_ok, pop, full, empty;
  logic [7:0]          count8;
  logic [31:0]         status;

  // Serializer state
  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                txd_q, txd_d;
  logic [31:0]         dout_q, dout_d;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0) && (state_q == S_IDLE);
  assign push_req = st & sel_tx;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push_ok  = push_req & (~full | pop);

  // FIFO byte storage; a dropped push never touches the array
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= di[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok) ovf_d = 1'b1;
    if (st && sel_st)         ovf_d = 1'b0;
  end

  // 8N1 serializer: next state, baud/bit counters and the registered txd level
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = 1'b1;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        txd_d = shift_q[0];
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // STATUS register image; count is zero-extended to a byte
  always_comb begin
    count8             = '0;
    count8[FIFO_LOG:0] = count_q;
    status             = {16'h0000, count8, 5'b00000, ovf_q, empty, full};
  end

  // Load data select; dout only moves on loads so stores can forward it safely
  always_comb begin
    dout_d = dout_q;
    if (ld) begin
      if (is_mmio) dout_d = sel_st ? status : 32'h0;
      else         dout_d = ram_q[ram_idx];
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      dout_q   <= dout_d;
    end
  end

  assign dout = dout_q;
  assign txd  = txd_q;

endmodule
